// File: rtl/idma_obi_sub_mem.sv
// rtl/idma_obi_sub_mem.sv - OBI subordinate with word memory and in-order response FIFO
// Grant is combinational from req; responses are queued and presented from the FIFO head.
module idma_obi_sub_mem #(
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          IdWidth        = 1,
  parameter int unsigned          NumWords       = 256,
  parameter logic [AddrWidth-1:0] BaseAddr       = '0,
  parameter int unsigned          MaxOutstanding = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               obi_a_req_i,
  input  logic [AddrWidth-1:0]               obi_a_addr_i,
  input  logic                               obi_a_we_i,
  input  logic [DataWidth/8-1:0]             obi_a_be_i,
  input  logic [DataWidth-1:0]               obi_a_wdata_i,
  input  logic [IdWidth-1:0]                 obi_a_aid_i,
  output logic                               obi_a_gnt_o,
  output logic                               obi_r_valid_o,
  output logic [DataWidth-1:0]               obi_r_rdata_o,
  output logic [IdWidth-1:0]                 obi_r_rid_o,
  output logic                               obi_r_err_o,
  input  logic                               obi_r_ready_i,
  input  logic                               stall_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic [31:0]                        wr_count_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned OffBits  = (BeWidth > 1) ? $clog2(BeWidth) : 0;
  localparam int unsigned IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam bit          ParamsOk = (DataWidth % 8 == 0) && (DataWidth >= 8) &&
                                     (MaxOutstanding >= 1) && (NumWords >= 1) &&
                                     (BaseAddr % BeWidth == 0);

  logic [DataWidth-1:0] mem [NumWords];

  logic [DataWidth-1:0] fifo_rdata [MaxOutstanding];
  logic [IdWidth-1:0]   fifo_rid   [MaxOutstanding];
  logic                 fifo_err   [MaxOutstanding];

  logic [PtrWidth-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntWidth-1:0]  count_q;
  logic [31:0]          wr_count_q;

  logic [AddrWidth-1:0] offset, word_off;
  logic [IdxWidth-1:0]  word_idx;
  logic                 in_range, push, pop, not_full, mem_write;
  logic [DataWidth-1:0] push_rdata;

  // Out-of-range accesses still take a FIFO slot so responses stay in grant order.
  assign offset   = obi_a_addr_i - BaseAddr;
  assign word_off = offset >> OffBits;
  assign in_range = (obi_a_addr_i >= BaseAddr) && (word_off < AddrWidth'(NumWords));
  assign word_idx = word_off[IdxWidth-1:0];

  assign obi_r_valid_o = (count_q != '0);
  assign pop           = obi_r_valid_o & obi_r_ready_i;
  assign not_full      = (count_q < CntWidth'(MaxOutstanding));
  assign obi_a_gnt_o   = obi_a_req_i & ~stall_i & rst_ni & (not_full | pop);
  assign push          = obi_a_req_i & obi_a_gnt_o;
  assign mem_write     = push & obi_a_we_i & in_range;
  assign push_rdata    = (!obi_a_we_i && in_range) ? mem[word_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (mem_write) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (obi_a_be_i[b]) mem[word_idx][b*8 +: 8] <= obi_a_wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rdata[wr_ptr_q] <= push_rdata;
      fifo_rid[wr_ptr_q]   <= obi_a_aid_i;
      fifo_err[wr_ptr_q]   <= ~in_range;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (mem_write && (wr_count_q != '1)) begin
        wr_count_q <= wr_count_q + 1'b1;
      end
    end
  end

  // Head storage is not reset, so gate it to present zeros while empty.
  assign obi_r_rdata_o = obi_r_valid_o ? fifo_rdata[rd_ptr_q] : '0;
  assign obi_r_rid_o   = obi_r_valid_o ? fifo_rid[rd_ptr_q]   : '0;
  assign obi_r_err_o   = obi_r_valid_o ? fifo_err[rd_ptr_q]   : 1'b0;
  assign outstanding_o = count_q;
  assign wr_count_o    = wr_count_q;

  a_params_legal: assert property (@(posedge clk_i) ParamsOk);

  a_aphase_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (obi_a_req_i && !obi_a_gnt_o) |=>
      (!obi_a_req_i || $stable({obi_a_addr_i, obi_a_we_i, obi_a_be_i, obi_a_wdata_i, obi_a_aid_i})));

  a_rphase_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (obi_r_valid_o && !obi_r_ready_i) |=>
      (obi_r_valid_o && $stable({obi_r_rdata_o, obi_r_rid_o, obi_r_err_o})));

endmodule

// File: tb/tb_idma_obi_sub_mem.sv
// tb/tb_idma_obi_sub_mem.sv - directed and random checks of idma_obi_sub_mem against a queue model
module tb_idma_obi_sub_mem;
  localparam int NW   = 256;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0, we = 1'b0, aid = 1'b0, stall = 1'b0, rready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rvalid, rid, rerr;
  logic [31:0] rdata, wr_count;
  logic [1:0]  outstanding;

  idma_obi_sub_mem #(
    .DataWidth(32), .AddrWidth(32), .IdWidth(1), .NumWords(NW),
    .BaseAddr(32'h0), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .obi_a_req_i(req), .obi_a_addr_i(addr), .obi_a_we_i(we), .obi_a_be_i(be),
    .obi_a_wdata_i(wdata), .obi_a_aid_i(aid), .obi_a_gnt_o(gnt),
    .obi_r_valid_o(rvalid), .obi_r_rdata_o(rdata), .obi_r_rid_o(rid), .obi_r_err_o(rerr),
    .obi_r_ready_i(rready), .stall_i(stall),
    .outstanding_o(outstanding), .wr_count_o(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] data; logic id; logic err;} resp_t;
  resp_t       exp_q[$];
  logic [31:0] ref_mem [NW];
  int unsigned ref_wc = 0;
  int          total = 0, bad = 0;

  logic        s_gnt, s_rv, s_rid, s_err;
  logic [31:0] s_rdata, s_wc;
  logic [1:0]  s_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample just before posedge, compare to model, advance model.
  task automatic cycle(input logic req_v, input logic we_v, input logic [31:0] addr_v,
                       input logic [3:0] be_v, input logic [31:0] wd_v, input logic aid_v,
                       input logic stall_v, input logic rdy_v, output logic g);
    logic   exp_gnt, inr;
    int     idx;
    resp_t  r;
    @(negedge clk);
    req = req_v; we = we_v; addr = addr_v; be = be_v; wdata = wd_v; aid = aid_v;
    stall = stall_v; rready = rdy_v;
    #4;
    s_gnt = gnt; s_rv = rvalid; s_rdata = rdata; s_rid = rid; s_err = rerr;
    s_out = outstanding; s_wc = wr_count;
    exp_gnt = req_v && !stall_v &&
              ((exp_q.size() < MAXO) || (exp_q.size() > 0 && rdy_v));
    chk("gnt", 64'(s_gnt), 64'(exp_gnt));
    chk("outstanding", 64'(s_out), 64'(exp_q.size()));
    chk("wr_count", 64'(s_wc), 64'(ref_wc));
    if (exp_q.size() > 0) begin
      chk("r_valid", 64'(s_rv), 64'(1));
      chk("r_rdata", 64'(s_rdata), 64'(exp_q[0].data));
      chk("r_rid", 64'(s_rid), 64'(exp_q[0].id));
      chk("r_err", 64'(s_err), 64'(exp_q[0].err));
      if (rdy_v) void'(exp_q.pop_front());
    end else begin
      chk("r_valid_idle", 64'(s_rv), 64'(0));
    end
    if (exp_gnt) begin
      idx = int'(addr_v / 4);
      inr = (addr_v / 4) < NW;
      r.id = aid_v;
      r.err = !inr;
      r.data = (!we_v && inr) ? ref_mem[idx] : 32'h0;
      exp_q.push_back(r);
      if (we_v && inr) begin
        for (int b = 0; b < 4; b++)
          if (be_v[b]) ref_mem[idx][b*8 +: 8] = wd_v[b*8 +: 8];
        ref_wc++;
      end
    end
    g = s_gnt;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    logic g;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, g);
  endtask

  // Hold one request until granted, with optional random stall injection.
  task automatic xfer(input logic we_v, input logic [31:0] addr_v, input logic [3:0] be_v,
                      input logic [31:0] wd_v, input logic aid_v, input logic rand_stall);
    logic g;
    g = 1'b0;
    for (int t = 0; t < 40 && !g; t++) begin
      cycle(1, we_v, addr_v, be_v, wd_v, aid_v,
            rand_stall ? 1'($urandom_range(0, 1)) : 1'b0, 1, g);
      chk("outstanding_le_max", 64'(s_out <= MAXO), 64'(1));
    end
    chk("grant_within_budget", 64'(g), 64'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) idle(1);
    chk("drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        g;
    logic [31:0] saved, wc_before;

    // Reset state, with a request present.
    req = 1'b1; rready = 1'b1;
    #3;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_rid", 64'(rid), 64'(0));
    chk("rst_err", 64'(rerr), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_wr_count", 64'(wr_count), 64'(0));
    @(negedge clk); req = 1'b0;
    @(negedge clk); rst_ni = 1'b1;

    // Basic write then read-after-write.
    cycle(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, 1, 0, 1, g);
    chk("t1_wr_gnt", 64'(s_gnt), 64'(1));
    cycle(1, 0, 32'h10, 4'h0, 32'h0, 0, 0, 1, g);
    chk("t1_wr_rvalid", 64'(s_rv), 64'(1));
    chk("t1_wr_rdata", 64'(s_rdata), 64'(0));
    chk("t1_wr_rid", 64'(s_rid), 64'(1));
    chk("t1_wr_err", 64'(s_err), 64'(0));
    idle(1);
    chk("t1_rd_rdata", 64'(s_rdata), 64'(32'hDEADBEEF));
    chk("t1_rd_rid", 64'(s_rid), 64'(0));
    chk("t1_wr_count", 64'(s_wc), 64'(1));
    drain();

    for (int i = 0; i < NW; i++) xfer(1, 32'(i * 4), 4'hF, $urandom, 1'($urandom), 0);
    drain();

    // Partial write.
    xfer(1, 32'h20, 4'hF, 32'hAABBCCDD, 0, 0);
    xfer(1, 32'h20, 4'b0101, 32'h11223344, 0, 0);
    xfer(0, 32'h20, 4'h0, 32'h0, 0, 0);
    drain();
    chk("t2_partial", 64'(s_rdata), 64'(32'hAA22CC44));

    // Back-pressure: FIFO fills, then a same-cycle pop re-enables grant.
    cycle(1, 0, 32'h40, 0, 0, 1, 0, 0, g); chk("t3_g1", 64'(g), 64'(1));
    cycle(1, 0, 32'h40, 0, 0, 1, 0, 0, g); chk("t3_g2", 64'(g), 64'(1));
    cycle(1, 0, 32'h40, 0, 0, 1, 0, 0, g); chk("t3_g3", 64'(g), 64'(0));
    chk("t3_full", 64'(s_out), 64'(2));
    cycle(1, 0, 32'h40, 0, 0, 1, 0, 0, g); chk("t3_g4", 64'(g), 64'(0));
    cycle(1, 0, 32'h40, 0, 0, 1, 0, 1, g); chk("t3_pop_gnt", 64'(g), 64'(1));
    drain();

    // Out-of-range write must not alias onto word 0.
    saved = ref_mem[0];
    wc_before = wr_count;
    xfer(1, 32'h400, 4'hF, ~saved, 1, 0);
    idle(1);
    chk("t4_err", 64'(s_err), 64'(1));
    chk("t4_rdata", 64'(s_rdata), 64'(0));
    chk("t4_wr_count", 64'(s_wc), 64'(wc_before));
    xfer(0, 32'h0, 4'h0, 0, 0, 0);
    idle(1);
    chk("t4_mem_unchanged", 64'(s_rdata), 64'(saved));
    chk("t4_rd_err", 64'(s_err), 64'(0));
    drain();

    // Streaming with random stalls and ignored low address bits.
    for (int i = 0; i < 64; i++)
      xfer(1, 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(0, 3)),
           4'($urandom), $urandom, 1'($urandom), 1);
    for (int i = 0; i < 64; i++)
      xfer(0, 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(0, 3)),
           4'($urandom), 0, 1'($urandom), 1);
    drain();

    // Reset with two queued responses.
    saved = ref_mem[5];
    cycle(1, 0, 32'h14, 0, 0, 0, 0, 0, g);
    cycle(1, 0, 32'h14, 0, 0, 1, 0, 0, g);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h14; rready = 1'b1; stall = 1'b0;
    #2;
    chk("t6_pre_gnt", 64'(gnt), 64'(1));
    chk("t6_pre_rvalid", 64'(rvalid), 64'(1));
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_gnt", 64'(gnt), 64'(0));
    chk("t6_rst_rvalid", 64'(rvalid), 64'(0));
    chk("t6_rst_outstanding", 64'(outstanding), 64'(0));
    exp_q.delete();
    @(negedge clk); req = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    ref_wc = 0;
    xfer(0, 32'h14, 4'h0, 0, 0, 0);
    idle(1);
    chk("t6_mem_kept", 64'(s_rdata), 64'(saved));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idma_obi_sub_mem.md
Name: idma_obi_sub_mem

Overview:
- OBI subordinate (responder) with an internal word-addressed memory.
- Terminates the OBI write manager port of the iDMA backend (r_axi_w_obi) and any other OBI initiator in the codebase.
- Accepts reads and writes, applies byte enables, echoes the transaction ID, and returns responses in order through an outstanding-response FIFO with rready back-pressure.
- Primary use is a bench and system-level target for iDMA OBI traffic; it is synthesizable.

Parameters:
- DataWidth, 32, data bus width in bits; multiple of 8.
- AddrWidth, 32, byte address width.
- IdWidth, 1, width of aid/rid.
- NumWords, 256, memory depth in DataWidth words.
- BaseAddr, 0, byte address of word 0; must be word aligned.
- MaxOutstanding, 2, response FIFO depth; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_a_req_i  in  1  address-phase request
- obi_a_addr_i  in  AddrWidth  byte address
- obi_a_we_i  in  1  1=write, 0=read
- obi_a_be_i  in  DataWidth/8  byte enables
- obi_a_wdata_i  in  DataWidth  write data
- obi_a_aid_i  in  IdWidth  transaction ID
- obi_a_gnt_o  out  1  address-phase grant
- obi_r_valid_o  out  1  response valid
- obi_r_rdata_o  out  DataWidth  read data (0 for writes and errors)
- obi_r_rid_o  out  IdWidth  echoed aid
- obi_r_err_o  out  1  access outside [BaseAddr, BaseAddr+NumWords*DataWidth/8)
- obi_r_ready_i  in  1  manager accepts response
- stall_i  in  1  grant-stall injection; forces gnt low
- outstanding_o  out  $clog2(MaxOutstanding+1)  responses currently queued
- wr_count_o  out  32  saturating count of granted in-range writes

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values:
  - gnt=0, r_valid=0, rdata=0, rid=0, err=0.
  - outstanding_o=0, wr_count_o=0.
  - FIFO empty. Memory contents are not reset.
- Grant:
  - gnt_o = req_i & ~stall_i & ~rst & (fifo_count < MaxOutstanding | pop_this_cycle), where pop = r_valid_o & r_ready_i.
  - Grant is combinational from req; a full FIFO that pops in the same cycle still grants, so there is no throughput bubble.
- Address decode:
  - word index = (addr - BaseAddr) >> log2(DataWidth/8); low offset bits are ignored.
  - Out of range (addr < BaseAddr or index >= NumWords): err=1, no memory update, rdata=0.
- Access on grant (req & gnt):
  - Write: updates each byte lane whose be bit is set, in the grant cycle (visible from the next cycle).
  - Read: samples the word in the grant cycle. be is ignored for reads; the full word is returned.
  - Push {rdata, aid, err} into the FIFO.
  - A read granted in the cycle after a write to the same word returns the new data.
- Response latency:
  - Minimum 1 cycle: r_valid rises the cycle after the grant when the FIFO was empty.
  - Responses are strictly in grant order; r outputs are driven from the FIFO head.
  - r outputs stay stable while r_valid & ~r_ready.
- Simultaneous push and pop: count unchanged; head advances correctly; a FIFO of depth 1 sustains 1 transaction per cycle.
- outstanding_o = FIFO occupancy, registered, updated every cycle.
- wr_count_o increments by 1 on each granted in-range write and saturates at 2^32-1; it does not count errored writes.
- Reset asserted mid-operation: all queued responses are dropped immediately (async). The manager must restart its transactions.
- req is not required to stay high without gnt (OBI allows it). The block keeps no state for an ungranted request.
- Assertions (sim only):
  - a-phase signals stable while req & ~gnt.
  - rdata/rid/err stable while r_valid & ~r_ready.
  - Parameter legality.

Test Plan:
- Write 0xDEADBEEF to 0x10 with be=4'b1111, aid=1, then read 0x10 with aid=0 → gnt same cycle; write response r_valid next cycle with rdata=0, rid=1, err=0; read returns 0xDEADBEEF, rid=0; wr_count_o=1.
- Partial write: write 0xAABBCCDD to 0x20 with be=4'b1111, then write 0x11223344 with be=4'b0101 → read of 0x20 returns 0xAA22CC44.
- Back-pressure with MaxOutstanding=2, r_ready=0, req held → exactly 2 grants, then gnt=0 and outstanding_o=2. Raising r_ready gives gnt in the same cycle as the pop; responses return in order.
- Out-of-range write to BaseAddr+NumWords*4 (0x400 at defaults) → err=1, rdata=0, memory unchanged, wr_count_o unchanged.
- Streaming 64 back-to-back writes then 64 reads with r_ready=1 and stall_i toggled randomly → one grant per non-stalled cycle; all read data match; outstanding_o never exceeds 2.
- Reset asserted with 2 responses queued → r_valid and gnt drop asynchronously; outstanding_o=0; after release, a read of a previously written word returns the old memory contents.
